// File: rtl/video_pkg.sv
// video_pkg: shared timing records, mode codes and colour-bar table for the video timing generator
package video_pkg;
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    logic hsync_pol;
    logic vsync_pol;
  } timing_t;
  localparam timing_t VGA_640x480 = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                     v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                                     hsync_pol: 1'b0, vsync_pol: 1'b0};
  localparam timing_t HD_1280x720 = '{h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
                                     v_active: 720, v_fp: 5, v_sync: 5, v_bp: 20,
                                     hsync_pol: 1'b1, vsync_pol: 1'b1};
  typedef enum logic [1:0] {TM_STREAM = 2'd0, TM_BARS = 2'd1, TM_RAMP = 2'd2, TM_SOLID = 2'd3} test_mode_t;
  localparam logic [0:7][23:0] BAR_RGB = {24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
endpackage

// File: rtl/video_timing_gen_fifo.sv
// pixel_fifo: first-word-fall-through synchronous FIFO with flush and full/empty flags
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    do_pop = pop && !empty;
    do_push = push && !flush && (!full || do_pop);
    rd_d = flush ? '0 : rd_q + (AW+1)'(do_pop);
    wr_d = flush ? '0 : wr_q + (AW+1)'(do_push);
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable VGA/DVI timing with prefetch FIFO, underflow flag and test patterns
module video_timing_gen import video_pkg::*; #(
  parameter int   H_ACTIVE   = VGA_640x480.h_active,
  parameter int   H_FP       = VGA_640x480.h_fp,
  parameter int   H_SYNC     = VGA_640x480.h_sync,
  parameter int   H_BP       = VGA_640x480.h_bp,
  parameter int   V_ACTIVE   = VGA_640x480.v_active,
  parameter int   V_FP       = VGA_640x480.v_fp,
  parameter int   V_SYNC     = VGA_640x480.v_sync,
  parameter int   V_BP       = VGA_640x480.v_bp,
  parameter logic HSYNC_POL  = VGA_640x480.hsync_pol,
  parameter logic VSYNC_POL  = VGA_640x480.vsync_pol,
  parameter int   FIFO_DEPTH = 4,
  parameter int   CW         = 12
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    test_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [23:0]   in_rgb,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_blank,
  output logic [CW-1:0] counter_x,
  output logic [CW-1:0] counter_y,
  output logic          next_line,
  output logic          next_field,
  output logic          underflow,
  input  logic          underflow_clr
);
  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSE = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] HT1 = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSE = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] VT1 = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [CW-1:0] x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
  logic [7:0] frame_q, frame_d;
  logic [23:0] rgb_q, rgb_d, pix, fifo_dout;
  logic hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, nl_q, nl_d, nf_q, nf_d, uf_q, uf_d;
  logic active, nf_int, stream, pop, push, flush, fifo_full, fifo_empty;
  logic [2:0] bar;
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(24)) u_fifo (
    .clk(clk_pixel),
    .rst_n(rst_n),
    .flush(flush),
    .push(push),
    .pop(pop),
    .din(in_rgb),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    active = enable && x_q < HA && y_q < VA;
    nf_int = enable && x_q == '0 && y_q == VA;
    stream = enable && test_mode == TM_STREAM;
    pop = active && stream;
    flush = !stream || nf_int;
    in_ready = rst_n && stream && !nf_int && (!fifo_full || pop);
    push = in_valid && in_ready;
    bar = 3'(32'(x_q) * 8 / H_ACTIVE);
    pix = test_mode == TM_BARS ? BAR_RGB[bar] :
          test_mode == TM_RAMP ? {8'(x_q), 8'(y_q), frame_q} :
          test_mode == TM_SOLID ? 24'hFFFFFF :
          fifo_empty ? 24'h0 : fifo_dout;
    x_d = !enable || x_q == HT1 ? '0 : x_q + 1'b1;
    y_d = !enable ? '0 : x_q != HT1 ? y_q : y_q == VT1 ? '0 : y_q + 1'b1;
    frame_d = frame_q + 8'(nf_int);
    uf_d = !underflow_clr && (uf_q || (pop && fifo_empty));
    rgb_d = active ? pix : 24'h0;
    hs_d = enable && x_q >= HS0 && x_q <= HSE ? HSYNC_POL : !HSYNC_POL;
    vs_d = enable && y_q >= VS0 && y_q <= VSE ? VSYNC_POL : !VSYNC_POL;
    blank_d = !active;
    cx_d = enable ? x_q : '0;
    cy_d = enable ? y_q : '0;
    nl_d = enable && x_q == HA;
    nf_d = nf_int;
  end
  always_ff @(posedge clk_pixel or negedge rst_n)
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      frame_q <= '0;
      rgb_q <= '0;
      hs_q <= !HSYNC_POL;
      vs_q <= !VSYNC_POL;
      blank_q <= 1'b1;
      nl_q <= 1'b0;
      nf_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      frame_q <= frame_d;
      rgb_q <= rgb_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      blank_q <= blank_d;
      nl_q <= nl_d;
      nf_q <= nf_d;
      uf_q <= uf_d;
    end
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;
  assign vga_blank = blank_q;
  assign counter_x = cx_q;
  assign counter_y = cy_q;
  assign next_line = nl_q;
  assign next_field = nf_q;
  assign underflow = uf_q;
endmodule
